// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder; the core's stall logic
// imports the same state and op types.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dmem_op_e;

  // Latency counter width: one spare bit above what the longest latency needs.
  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return $clog2(max_lat) + 1;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the responder: synchronous write, registered read port,
// whole array and read register cleared synchronously on reset.
module dmem_resp_array
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage and read register; rdata holds its value between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem_r[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem_r[raddr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's load/store port: one request at a time,
// fixed read/write latency, single-cycle response pulses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_rd,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_wack,
  output logic              o_err
);

  localparam int CNT_W = cnt_width(RD_LAT, WR_LAT);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  dmem_state_e       state_r;
  dmem_state_e       state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  dmem_op_e          op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              accept_s;
  logic              illegal_s;
  logic              commit_s;
  logic              ready_r;
  logic              rvalid_r;
  logic              wack_r;
  logic              err_r;

  // Next-state, latency countdown and per-cycle strobes.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    illegal_s = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (i_req_rd ^ i_req_wr) begin
          accept_s = 1'b1;
          state_s  = ST_BUSY;
          cnt_s    = i_req_wr ? WR_LOAD : RD_LOAD;
        end else if (i_req_rd & i_req_wr) begin
          illegal_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == '0) begin
          state_s  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, request capture and registered response flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      op_r     <= OP_RD;
      addr_r   <= '0;
      wdata_r  <= '0;
      ready_r  <= 1'b1;
      rvalid_r <= 1'b0;
      wack_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ready_r  <= (state_s != ST_BUSY);
      rvalid_r <= commit_s & (op_r == OP_RD);
      wack_r   <= commit_s & (op_r == OP_WR);
      err_r    <= illegal_s;
      if (accept_s) begin
        op_r    <= i_req_wr ? OP_WR : OP_RD;
        addr_r  <= i_addr;
        wdata_r <= i_wdata;
      end
    end
  end

  dmem_resp_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (commit_s & (op_r == OP_WR)),
    .waddr (addr_r),
    .wdata (wdata_r),
    .re    (commit_s & (op_r == OP_RD)),
    .raddr (addr_r),
    .rdata (o_rdata)
  );

  assign o_ready  = ready_r;
  assign o_rvalid = rvalid_r;
  assign o_wack   = wack_r;
  assign o_err    = err_r;

endmodule
